// File: rtl/uart_rx_frame_ctrl_if.sv
// uart_rx_frame_ctrl_if: byte-valid, drain handshake and frame report signals
// between the UART receiver/consumer side and the frame controller.
interface uart_rx_frame_ctrl_if;
    logic       uart_rx_vld;
    logic       buf_rd_done_1;
    logic       buf_rd_done_2;
    logic       uart_rx_vld_o;
    logic       frame_ping_pong_flag;
    logic       frame_done;
    logic       frame_buf_sel;
    logic [9:0] frame_len;
    logic       frame_ovf;
    logic       buf_full_1;
    logic       buf_full_2;
    logic [7:0] drop_frame_cnt;
    modport master (
        output uart_rx_vld, buf_rd_done_1, buf_rd_done_2,
        input  uart_rx_vld_o, frame_ping_pong_flag, frame_done, frame_buf_sel,
               frame_len, frame_ovf, buf_full_1, buf_full_2, drop_frame_cnt
    );
    modport slave (
        input  uart_rx_vld, buf_rd_done_1, buf_rd_done_2,
        output uart_rx_vld_o, frame_ping_pong_flag, frame_done, frame_buf_sel,
               frame_len, frame_ovf, buf_full_1, buf_full_2, drop_frame_cnt
    );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: splits received bytes into frames on idle gaps and steers
// them into a ping-pong buffer pair, dropping frames when both buffers are full.
module uart_rx_frame_ctrl #(
    parameter int IDLE_CYCLES = 15190,
    parameter int CNT_W       = 16,
    parameter int MAX_LEN     = 1020
) (
    input logic                 clk,
    input logic                 rst,
    uart_rx_frame_ctrl_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RECV = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DROP = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] idle_cnt;
    logic [9:0]       len_cnt;
    logic             ovf;
    logic             flag;
    logic             full_1;
    logic             full_2;
    logic             done;
    logic             sel;
    logic [9:0]       len;
    logic             len_ovf;
    logic [7:0]       drop_cnt;
    logic             gap;
    logic             other_free;
    logic             set_1;
    logic             set_2;

    // a drain of the other buffer in this very cycle already counts as free
    always_comb begin
        gap        = (state == RECV || state == DROP) && !bus.uart_rx_vld
                     && idle_cnt == CNT_W'(IDLE_CYCLES - 1);
        other_free = flag ? (!full_1 || bus.buf_rd_done_1) : (!full_2 || bus.buf_rd_done_2);
        set_1      = gap && state == RECV && !flag;
        set_2      = gap && state == RECV && flag;
    end

    assign bus.uart_rx_vld_o        = bus.uart_rx_vld && (state == IDLE || state == RECV)
                                      && len_cnt < 10'(MAX_LEN);
    assign bus.frame_ping_pong_flag = flag;
    assign bus.frame_done           = done;
    assign bus.frame_buf_sel        = sel;
    assign bus.frame_len            = len;
    assign bus.frame_ovf            = len_ovf;
    assign bus.buf_full_1           = full_1;
    assign bus.buf_full_2           = full_2;
    assign bus.drop_frame_cnt       = drop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idle_cnt <= '0;
            len_cnt  <= '0;
            ovf      <= 1'b0;
            flag     <= 1'b0;
            full_1   <= 1'b0;
            full_2   <= 1'b0;
            done     <= 1'b0;
            sel      <= 1'b0;
            len      <= '0;
            len_ovf  <= 1'b0;
            drop_cnt <= '0;
        end else begin
            done   <= 1'b0;
            full_1 <= set_1 || (full_1 && !bus.buf_rd_done_1);
            full_2 <= set_2 || (full_2 && !bus.buf_rd_done_2);
            case (state)
                IDLE: if (bus.uart_rx_vld) begin
                    state    <= RECV;
                    len_cnt  <= 10'd1;
                    ovf      <= 1'b0;
                    idle_cnt <= '0;
                end
                RECV: if (bus.uart_rx_vld) begin
                    idle_cnt <= '0;
                    len_cnt  <= len_cnt < 10'(MAX_LEN) ? len_cnt + 10'd1 : len_cnt;
                    ovf      <= ovf || len_cnt >= 10'(MAX_LEN);
                end else if (gap) begin
                    done    <= 1'b1;
                    sel     <= flag;
                    len     <= len_cnt;
                    len_ovf <= ovf;
                    len_cnt <= '0;
                    flag    <= flag ^ other_free;
                    state   <= other_free ? IDLE : WAIT;
                end else begin
                    idle_cnt <= idle_cnt + CNT_W'(1);
                end
                WAIT: if (bus.uart_rx_vld) begin
                    state    <= DROP;
                    idle_cnt <= '0;
                    drop_cnt <= drop_cnt == 8'hFF ? drop_cnt : drop_cnt + 8'd1;
                end else if (other_free) begin
                    flag  <= !flag;
                    state <= IDLE;
                end
                DROP: if (bus.uart_rx_vld) begin
                    idle_cnt <= '0;
                end else if (gap) begin
                    flag  <= flag ^ other_free;
                    state <= other_free ? IDLE : WAIT;
                end else begin
                    idle_cnt <= idle_cnt + CNT_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: directed test-plan scenarios plus random byte traffic,
// checked cycle by cycle against a timestamp-based frame model.
module tb_uart_rx_frame_ctrl;
    localparam int IDLE = 100;
    localparam int MAXL = 1020;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_frame_ctrl_if bus();
    uart_rx_frame_ctrl #(.IDLE_CYCLES(IDLE), .CNT_W(16), .MAX_LEN(MAXL)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int passed = 0;
    int total  = 0;

    // model: frame end is detected from the timestamp of the last byte
    int         t = 0;
    int         m_last = 0;
    int         m_mode = 0;
    bit         m_wait = 0;
    logic       m_tgt = 0;
    logic [1:0] m_full = 0;
    int         m_cnt = 0;
    bit         m_over = 0;
    logic [7:0] m_drops = 0;
    logic       e_done = 0;
    logic       e_sel = 0;
    logic [9:0] e_len = 0;
    logic       e_ovf = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at t=%0d", tag, got, exp, t);
    endtask

    task automatic model_step(bit r, bit v, bit d1, bit d2);
        logic [1:0] rd;
        logic [1:0] nf;
        bit         ofree;
        t++;
        rd = {d2, d1};
        if (r) begin
            m_mode = 0; m_wait = 0; m_tgt = 0; m_full = 0; m_cnt = 0; m_over = 0;
            m_drops = 0; e_done = 0; e_sel = 0; e_len = 0; e_ovf = 0;
            return;
        end
        ofree  = !m_full[!m_tgt] || rd[!m_tgt];
        nf     = m_full & ~rd;
        e_done = 0;
        if (m_wait) begin
            if (v) begin
                m_wait = 0; m_mode = 2; m_last = t;
                m_drops = m_drops == 8'hFF ? m_drops : m_drops + 8'd1;
            end else if (ofree) begin
                m_wait = 0; m_tgt = !m_tgt;
            end
        end else if (m_mode == 0) begin
            if (v) begin
                m_mode = 1; m_cnt = 1; m_over = 0; m_last = t;
            end
        end else if (v) begin
            m_last = t;
            if (m_mode == 1) begin
                if (m_cnt < MAXL) m_cnt++;
                else m_over = 1;
            end
        end else if (t - m_last == IDLE) begin
            if (m_mode == 1) begin
                e_done = 1; e_sel = m_tgt; e_len = 10'(m_cnt); e_ovf = m_over;
                nf[m_tgt] = 1'b1;
                m_cnt = 0;
            end
            m_mode = 0;
            if (ofree) m_tgt = !m_tgt;
            else m_wait = 1;
        end
        m_full = nf;
    endtask

    task automatic cycle(bit r, bit v, bit d1, bit d2);
        @(negedge clk);
        rst = r;
        bus.uart_rx_vld   = v;
        bus.buf_rd_done_1 = d1;
        bus.buf_rd_done_2 = d2;
        #1;
        if (!r) check("vld_o", bus.uart_rx_vld_o, v && !m_wait && m_mode != 2 && m_cnt < MAXL);
        model_step(r, v, d1, d2);
        @(posedge clk);
        #1;
        check("regs",
              {bus.frame_done, bus.frame_ping_pong_flag, bus.frame_buf_sel, bus.frame_len,
               bus.frame_ovf, bus.buf_full_1, bus.buf_full_2, bus.drop_frame_cnt},
              {e_done, m_tgt, e_sel, e_len, e_ovf, m_full[0], m_full[1], m_drops});
    endtask

    task automatic idle(int n);
        repeat (n) cycle(0, 0, 0, 0);
    endtask

    task automatic bytes(int n, int gap);
        repeat (n) begin
            cycle(0, 1, 0, 0);
            idle(gap);
        end
    endtask

    task automatic frame(int n);
        bytes(n, 1);
        idle(IDLE + 5);
    endtask

    task automatic do_reset();
        cycle(1, 0, 0, 0);
    endtask

    initial begin
        bus.uart_rx_vld   = 0;
        bus.buf_rd_done_1 = 0;
        bus.buf_rd_done_2 = 0;
        do_reset();
        do_reset();
        check("rst_flag", bus.frame_ping_pong_flag, 0);
        check("rst_len", bus.frame_len, 0);

        bytes(5, 19);
        idle(80);
        cycle(0, 0, 0, 0);
        check("f1_done", bus.frame_done, 1);
        check("f1_len", bus.frame_len, 5);
        check("f1_sel", bus.frame_buf_sel, 0);
        check("f1_flag", bus.frame_ping_pong_flag, 1);
        check("f1_full1", bus.buf_full_1, 1);
        idle(5);

        repeat (1025) cycle(0, 1, 0, 0);
        idle(IDLE);
        check("ovf_done", bus.frame_done, 1);
        check("ovf_len", bus.frame_len, 1020);
        check("ovf_flag", bus.frame_ovf, 1);
        cycle(0, 0, 1, 1);
        idle(2);

        do_reset();
        frame(2);
        frame(2);
        frame(3);
        check("drop_cnt", bus.drop_frame_cnt, 1);
        cycle(0, 0, 1, 0);
        check("drop_flag", bus.frame_ping_pong_flag, 0);
        frame(4);
        check("f4_len", bus.frame_len, 4);
        check("f4_sel", bus.frame_buf_sel, 0);

        do_reset();
        frame(1);
        frame(1);
        cycle(0, 0, 1, 0);
        cycle(0, 1, 0, 0);
        idle(IDLE - 1);
        cycle(0, 1, 0, 0);
        idle(IDLE - 1);
        cycle(0, 0, 0, 1);
        check("ext_done", bus.frame_done, 1);
        check("ext_len", bus.frame_len, 2);
        check("same_flag", bus.frame_ping_pong_flag, 1);
        check("same_full2", bus.buf_full_2, 0);
        idle(3);

        do_reset();
        frame(1);
        frame(1);
        cycle(0, 1, 1, 0);
        idle(IDLE - 1);
        cycle(0, 0, 0, 0);
        check("wd_drops", bus.drop_frame_cnt, 1);
        check("wd_flag", bus.frame_ping_pong_flag, 0);

        bytes(3, 1);
        do_reset();
        check("mid_len", bus.frame_len, 0);
        frame(2);
        check("post_len", bus.frame_len, 2);
        check("post_sel", bus.frame_buf_sel, 0);

        repeat (40) begin
            repeat ($urandom_range(1, 6)) begin
                cycle(0, 1, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
                repeat ($urandom_range(0, 3) == 0 ? $urandom_range(IDLE - 2, IDLE + 2)
                                                   : $urandom_range(0, 30))
                    cycle(0, 0, $urandom_range(0, 40) == 0, $urandom_range(0, 40) == 0);
            end
            repeat (IDLE + $urandom_range(0, 20))
                cycle(0, 0, $urandom_range(0, 60) == 0, $urandom_range(0, 60) == 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
